// File: rtl/avalon_pcp_pkg.sv
// Shared types and constants for the PCP Avalon-MM register slave.
// State encodings, error read-back pattern and helper functions.
package avalon_pcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    localparam logic [31:0] C_ERR_DATA = 32'hDEAD_BEEF;

    // Bits needed to hold a wait-state count of n (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Merge new data into a word on the lanes selected by be.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_pcp_reg_slave_if.sv
// Avalon-MM PCP bus between the bridge (master) and the register slave.
interface avalon_pcp_reg_slave_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avs_pcp_reg_array.sv
// Word storage for the PCP register bank: byte-enable write port,
// asynchronous read port.
module avs_pcp_reg_array
    import avalon_pcp_pkg::*;
#(
    parameter int unsigned C_ADDR_BITS = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   wr_en,
    input  logic [C_ADDR_BITS-1:0] wr_idx,
    input  logic [3:0]             wr_be,
    input  logic [31:0]            wr_data,
    input  logic [C_ADDR_BITS-1:0] rd_idx,
    output logic [31:0]            rd_data
);

    localparam int unsigned C_WORDS = 2 ** C_ADDR_BITS;

    logic [31:0] mem_r [C_WORDS];

    // Storage: cleared on reset, lane-merged on write.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= be_merge(mem_r[wr_idx], wr_data, wr_be);
        end else begin
            mem_r[wr_idx] <= mem_r[wr_idx];
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/avalon_pcp_reg_slave.sv
// Avalon-MM register slave for the PCP bridge: address decode, wait-state FSM,
// registered read data and a saturating error counter.
module avalon_pcp_reg_slave
    import avalon_pcp_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter int unsigned C_ADDR_BITS   = 4,
    parameter int unsigned C_WAIT_STATES = 2,
    parameter logic [31:0] C_ID          = 32'hA0B1_0001
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    avalon_pcp_reg_slave_if.slave avs,
    output logic [7:0]            err_count
);

    localparam int unsigned C_CW          = cnt_width(C_WAIT_STATES);
    localparam int unsigned C_CNT_LOAD_I  = (C_WAIT_STATES == 0) ? 0 : C_WAIT_STATES - 1;
    localparam logic [32:0] C_SPAN        = 33'd4 << C_ADDR_BITS;

    state_t                 state_r;
    logic [C_CW-1:0]        cnt_r;
    logic                   is_write_r;
    logic                   in_range_r;
    logic [C_ADDR_BITS-1:0] idx_r;
    logic [3:0]             be_r;
    logic [31:0]            wdata_r;
    logic [31:0]            readdata_r;
    logic                   waitreq_r;
    logic [7:0]             err_r;

    logic [31:0]            off_s;
    logic                   in_range_s;
    logic [C_ADDR_BITS-1:0] idx_s;
    logic                   req_s;
    logic [C_ADDR_BITS-1:0] rd_idx_s;
    logic                   rd_in_range_s;
    logic [31:0]            arr_rdata_s;
    logic [31:0]            rd_val_s;
    logic                   wr_en_s;
    logic                   err_evt_s;

    assign off_s      = avs.address - C_BASEADDR;
    assign in_range_s = (avs.address >= C_BASEADDR) && ({1'b0, off_s} < C_SPAN);
    assign idx_s      = off_s[C_ADDR_BITS+1:2];
    assign req_s      = avs.read || avs.write;

    // With zero wait states ACK follows IDLE directly, so the read mux must see the live decode.
    assign rd_idx_s      = (state_r == ST_IDLE) ? idx_s      : idx_r;
    assign rd_in_range_s = (state_r == ST_IDLE) ? in_range_s : in_range_r;

    // Writes land on the edge that ends ACK; word 0 and out-of-range writes are dropped.
    assign wr_en_s = (state_r == ST_ACK) && is_write_r && in_range_r &&
                     (idx_r != {C_ADDR_BITS{1'b0}});

    avs_pcp_reg_array #(
        .C_ADDR_BITS (C_ADDR_BITS)
    ) u_array (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_r),
        .wr_be   (be_r),
        .wr_data (wdata_r),
        .rd_idx  (rd_idx_s),
        .rd_data (arr_rdata_s)
    );

    // Read source selection: ID word, stored word or error pattern.
    always_comb begin
        rd_val_s = C_ERR_DATA;
        if (!rd_in_range_s) begin
            rd_val_s = C_ERR_DATA;
        end else if (rd_idx_s == {C_ADDR_BITS{1'b0}}) begin
            rd_val_s = C_ID;
        end else begin
            rd_val_s = arr_rdata_s;
        end
    end

    // Error event detection; events live in distinct states, so at most one fires per cycle.
    always_comb begin
        err_evt_s = 1'b0;
        case (state_r)
            ST_IDLE: err_evt_s = avs.read && avs.write;
            ST_BUSY: err_evt_s = !req_s;
            ST_ACK:  err_evt_s = !in_range_r;
            default: err_evt_s = 1'b0;
        endcase
    end

    // Transaction FSM with registered waitrequest and readdata.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {C_CW{1'b0}};
            is_write_r <= 1'b0;
            in_range_r <= 1'b0;
            idx_r      <= {C_ADDR_BITS{1'b0}};
            be_r       <= 4'h0;
            wdata_r    <= 32'h0000_0000;
            readdata_r <= 32'h0000_0000;
            waitreq_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    waitreq_r <= 1'b1;
                    if (req_s) begin
                        // A simultaneous read and write serves the write first.
                        is_write_r <= avs.write;
                        in_range_r <= in_range_s;
                        idx_r      <= idx_s;
                        be_r       <= avs.byteenable;
                        wdata_r    <= avs.writedata;
                        if (C_WAIT_STATES == 0) begin
                            state_r   <= ST_ACK;
                            waitreq_r <= 1'b0;
                            if (!avs.write) begin
                                readdata_r <= rd_val_s;
                            end else begin
                                readdata_r <= readdata_r;
                            end
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= C_CW'(C_CNT_LOAD_I);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!req_s) begin
                        state_r   <= ST_IDLE;
                        waitreq_r <= 1'b1;
                    end else if (cnt_r == {C_CW{1'b0}}) begin
                        state_r   <= ST_ACK;
                        waitreq_r <= 1'b0;
                        if (!is_write_r) begin
                            readdata_r <= rd_val_s;
                        end else begin
                            readdata_r <= readdata_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - C_CW'(1);
                    end
                end
                ST_ACK: begin
                    state_r   <= ST_IDLE;
                    waitreq_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    waitreq_r <= 1'b1;
                end
            endcase
        end
    end

    // Saturating error counter.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            err_r <= 8'h00;
        end else if (err_evt_s && (err_r != 8'hFF)) begin
            err_r <= err_r + 8'h01;
        end else begin
            err_r <= err_r;
        end
    end

    assign avs.readdata    = readdata_r;
    assign avs.waitrequest = waitreq_r;
    assign err_count       = err_r;

endmodule

// File: tb/tb_avalon_pcp_reg_slave.sv
// Scoreboard bench for avalon_pcp_reg_slave: directed vectors plus a
// reference-model random phase; a monitor checks every completion.
`timescale 1ns/1ps
module tb_avalon_pcp_reg_slave;
    import avalon_pcp_pkg::*;

    localparam int unsigned W  = 2;
    localparam logic [31:0] ID = 32'hA0B1_0001;

    logic       ACLK    = 1'b0;
    logic       ARESETN = 1'b0;
    logic [7:0] err_count;

    avalon_pcp_reg_slave_if avs();

    avalon_pcp_reg_slave #(
        .C_BASEADDR    (32'h0000_0000),
        .C_ADDR_BITS   (4),
        .C_WAIT_STATES (W),
        .C_ID          (ID)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .avs       (avs),
        .err_count (err_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          start;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] mdl [16];
    int          mdl_err;

    always @(posedge ACLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pops one expectation.
    always @(negedge ACLK) begin
        exp_t e;
        if (ARESETN && (avs.waitrequest === 1'b0)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got waitrequest 0 expected 1 (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("latency", 32'(cyc - e.start), 32'(1 + W));
                if (e.is_read) chk("readdata", avs.readdata, e.data);
            end
        end
    end

    task automatic drive(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        avs.read       = rd;
        avs.write      = wr;
        avs.address    = addr;
        avs.byteenable = be;
        avs.writedata  = wdata;
    endtask

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge ACLK);
            if (avs.waitrequest === 1'b0) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack expected ack within 30 cycles", name);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic xact(input bit rd, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp);
        @(posedge ACLK); #1;
        drive(rd, !rd, addr, be, wdata);
        sb_q.push_back('{is_read: rd, data: exp, start: cyc});
        wait_ack(rd ? "read" : "write");
        drive(1'b0, 1'b0, addr, 4'h0, 32'h0);
    endtask

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        if (a >= 32'd64) return 32'hDEAD_BEEF;
        if (a[5:2] == 4'd0) return ID;
        return mdl[a[5:2]];
    endfunction

    initial begin
        logic [31:0] a, d, e;
        logic [3:0]  be;
        bit          rd;

        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        // T1 reset
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_waitreq", {31'd0, avs.waitrequest}, 32'd1);
        chk("rst_readdata", avs.readdata, 32'h0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        ARESETN = 1'b1;
        for (int i = 1; i < 16; i++) xact(1'b1, 32'(4 * i), 4'h0, 32'h0, 32'h0);

        // T2 write then read
        xact(1'b0, 32'h4, 4'hF, 32'h1234_5678, 32'h0);
        xact(1'b1, 32'h4, 4'h0, 32'h0, 32'h1234_5678);

        // T3 byte lanes, and a be=0 write that still completes
        xact(1'b0, 32'h8, 4'hF, 32'hFFFF_FFFF, 32'h0);
        xact(1'b0, 32'h8, 4'b0001, 32'h0000_00AA, 32'h0);
        xact(1'b1, 32'h8, 4'h0, 32'h0, 32'hFFFF_FFAA);
        xact(1'b0, 32'h8, 4'h0, 32'h1111_1111, 32'h0);
        xact(1'b1, 32'hA, 4'h0, 32'h0, 32'hFFFF_FFAA);

        // T4 out of range and word 0
        xact(1'b1, 32'h40, 4'h0, 32'h0, 32'hDEAD_BEEF);
        chk("oor_read_err", {24'd0, err_count}, 32'd1);
        xact(1'b0, 32'h40, 4'hF, 32'h9999_9999, 32'h0);
        chk("oor_write_err", {24'd0, err_count}, 32'd2);
        xact(1'b1, 32'h4, 4'h0, 32'h0, 32'h1234_5678);
        xact(1'b0, 32'h0, 4'hF, 32'h7777_7777, 32'h0);
        xact(1'b1, 32'h0, 4'h0, 32'h0, ID);
        chk("word0_write_err", {24'd0, err_count}, 32'd2);

        // T5 collision: write first, then the held read
        @(posedge ACLK); #1;
        drive(1'b1, 1'b1, 32'h8, 4'hF, 32'h0000_0055);
        sb_q.push_back('{is_read: 1'b0, data: 32'h0, start: cyc});
        wait_ack("coll_write");
        avs.write = 1'b0;
        sb_q.push_back('{is_read: 1'b1, data: 32'h0000_0055, start: cyc});
        wait_ack("coll_read");
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("collision_err", {24'd0, err_count}, 32'd3);

        // Withdrawn read: no completion, one error event
        @(posedge ACLK); #1;
        drive(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        @(posedge ACLK); #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (4) @(posedge ACLK);
        #1;
        chk("withdraw_err", {24'd0, err_count}, 32'd4);

        // T6 reset during BUSY of a write to 0xC
        @(posedge ACLK); #1;
        drive(1'b0, 1'b1, 32'hC, 4'hF, 32'hCAFE_F00D);
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        chk("midrst_waitreq", {31'd0, avs.waitrequest}, 32'd1);
        chk("midrst_errcnt", {24'd0, err_count}, 32'd0);
        xact(1'b1, 32'hC, 4'h0, 32'h0, 32'h0);

        // Random accesses against the reference model
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        mdl_err = 0;
        for (int i = 0; i < 500; i++) begin
            a  = 32'($urandom_range(0, 79));
            rd = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            e  = mdl_read(a);
            xact(rd, a, be, d, e);
            if (a >= 32'd64) mdl_err++;
            else if (!rd && (a[5:2] != 4'd0)) mdl[a[5:2]] = be_merge(mdl[a[5:2]], d, be);
        end
        chk("random_errcnt", {24'd0, err_count}, 32'(mdl_err));
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end expected end before 500us");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
